// File: rtl/simm_burst_sequencer.sv
// ----------------------------------------------------------------------------
// simm_burst_sequencer: 68030 bus cycles and CBREQ line fills -> simm_controller
// Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module simm_burst_sequencer #(
  parameter int unsigned BURST_ENABLE   = 1,
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       cpu_as,
  input  logic       cpu_ds,
  input  logic       cpu_rn_w,
  input  logic [1:0] cpu_siz,
  input  logic [3:0] cpu_addr_low,
  input  logic       dram_sel,
  input  logic       cbreq,
  input  logic       waitstate,
  output logic       mem_cs,
  output logic       mem_ds,
  output logic       mem_rn_w,
  output logic [3:0] byte_selects,
  output logic [1:0] beat_addr,
  output logic       ack,
  output logic       cback,
  output logic       berr,
  output logic       busy
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    GAP    = 2'd2,
    HOLD   = 2'd3
  } state_t;

  localparam logic [7:0] WDOG_LAST = 8'(TIMEOUT_CYCLES - 1);

  state_t     state_q, state_d;
  logic       mem_cs_q, mem_cs_d;
  logic       mem_ds_q, mem_ds_d;
  logic       mem_rn_w_q, mem_rn_w_d;
  logic [3:0] byte_sel_q, byte_sel_d;
  logic [1:0] beat_addr_q, beat_addr_d;
  logic       ack_q, ack_d;
  logic       cback_q, cback_d;
  logic       berr_q, berr_d;
  logic       busy_q, busy_d;
  logic       burst_q, burst_d;
  logic [1:0] beat_cnt_q, beat_cnt_d;
  logic [7:0] wdog_q, wdog_d;

  logic       req;
  logic       burst_ok;
  logic [3:0] req_bs;

  assign req      = cpu_as && cpu_ds && dram_sel;
  assign burst_ok = (BURST_ENABLE != 0) && cbreq && cpu_rn_w && (cpu_siz == 2'b00);

  // Lane decode: bit3 is D31:24, i.e. the byte at A[1:0]=00.
  always_comb begin
    req_bs = 4'b0001;
    case ({cpu_siz, cpu_addr_low[1:0]})
      4'b01_00: req_bs = 4'b1000;
      4'b01_01: req_bs = 4'b0100;
      4'b01_10: req_bs = 4'b0010;
      4'b10_00: req_bs = 4'b1100;
      4'b10_01: req_bs = 4'b0110;
      4'b10_10: req_bs = 4'b0011;
      4'b11_00: req_bs = 4'b1110;
      4'b11_01: req_bs = 4'b0111;
      4'b11_10: req_bs = 4'b0011;
      4'b00_00: req_bs = 4'b1111;
      4'b00_01: req_bs = 4'b0111;
      4'b00_10: req_bs = 4'b0011;
      default:  req_bs = 4'b0001;
    endcase
  end

  always_comb begin
    state_d     = state_q;
    mem_cs_d    = mem_cs_q;
    mem_ds_d    = mem_ds_q;
    mem_rn_w_d  = mem_rn_w_q;
    byte_sel_d  = byte_sel_q;
    beat_addr_d = beat_addr_q;
    ack_d       = 1'b0;
    berr_d      = 1'b0;
    cback_d     = cback_q;
    burst_d     = burst_q;
    beat_cnt_d  = beat_cnt_q;
    wdog_d      = wdog_q;

    case (state_q)
      IDLE: begin
        if (req) begin
          mem_rn_w_d  = cpu_rn_w;
          byte_sel_d  = burst_ok ? 4'b1111 : req_bs;
          beat_addr_d = cpu_addr_low[3:2];
          burst_d     = burst_ok;
          beat_cnt_d  = 2'd0;
          wdog_d      = 8'd0;
          mem_cs_d    = 1'b1;
          mem_ds_d    = 1'b1;
          cback_d     = burst_ok;
          state_d     = ACCESS;
        end
      end
      ACCESS: begin
        if (!waitstate) begin
          ack_d    = 1'b1;
          mem_cs_d = 1'b0;
          mem_ds_d = 1'b0;
          wdog_d   = 8'd0;
          if (!burst_q || (beat_cnt_q == 2'd3) || !cbreq) begin
            cback_d = 1'b0;
            state_d = HOLD;
          end else begin
            beat_addr_d = beat_addr_q + 2'd1;
            beat_cnt_d  = beat_cnt_q + 2'd1;
            state_d     = GAP;
          end
        end else if (wdog_q == WDOG_LAST) begin
          berr_d   = 1'b1;
          mem_cs_d = 1'b0;
          mem_ds_d = 1'b0;
          cback_d  = 1'b0;
          state_d  = HOLD;
        end else begin
          wdog_d = wdog_q + 8'd1;
        end
      end
      GAP: begin
        // Losing the address strobe wins over restarting the next beat.
        if (!cpu_as) begin
          cback_d = 1'b0;
          state_d = HOLD;
        end else if (waitstate) begin
          mem_cs_d = 1'b1;
          mem_ds_d = 1'b1;
          state_d  = ACCESS;
        end
      end
      HOLD: begin
        cback_d = 1'b0;
        if (!cpu_as) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase

    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q     <= IDLE;
      mem_cs_q    <= 1'b0;
      mem_ds_q    <= 1'b0;
      mem_rn_w_q  <= 1'b0;
      byte_sel_q  <= 4'b0000;
      beat_addr_q <= 2'd0;
      ack_q       <= 1'b0;
      cback_q     <= 1'b0;
      berr_q      <= 1'b0;
      busy_q      <= 1'b0;
      burst_q     <= 1'b0;
      beat_cnt_q  <= 2'd0;
      wdog_q      <= 8'd0;
    end else begin
      state_q     <= state_d;
      mem_cs_q    <= mem_cs_d;
      mem_ds_q    <= mem_ds_d;
      mem_rn_w_q  <= mem_rn_w_d;
      byte_sel_q  <= byte_sel_d;
      beat_addr_q <= beat_addr_d;
      ack_q       <= ack_d;
      cback_q     <= cback_d;
      berr_q      <= berr_d;
      busy_q      <= busy_d;
      burst_q     <= burst_d;
      beat_cnt_q  <= beat_cnt_d;
      wdog_q      <= wdog_d;
    end
  end

  assign mem_cs       = mem_cs_q;
  assign mem_ds       = mem_ds_q;
  assign mem_rn_w     = mem_rn_w_q;
  assign byte_selects = byte_sel_q;
  assign beat_addr    = beat_addr_q;
  assign ack          = ack_q;
  assign cback        = cback_q;
  assign berr         = berr_q;
  assign busy         = busy_q;

endmodule

`default_nettype wire
